rf_scoreboard: RTL
==================

// Module: rf_scoreboard
// PURPOSE
//  Parametrised register file: XLEN-bit words, NREG entries, 2 async read ports, 1 sync write port.
//  Adds a per-register busy scoreboard (set on allocate, cleared on writeback) for pipelined hazard
//  detection, plus a reset-time clear sequencer that zeroes storage one entry per cycle.
//  Sits between decode (reads, allocate) and writeback (write) in the pipelined core.
// PARAMETERS
//  XLEN  32  data word width in bits
//  NREG  32  number of registers, >=2; entry 0 hardwired to zero
//  AW    5   address width; must satisfy 2**AW >= NREG
// PORTS
//  i_clk         in   1     global clock
//  i_rst         in   1     synchronous active-high reset
//  o_ready       out  1     1 = clear sequence done, file usable
//  i_rs1_raddr   in   AW    read port 1 address
//  o_rs1_rdata   out  XLEN  read port 1 data (combinational)
//  o_rs1_busy    out  1     read port 1 register has outstanding producer
//  i_rs2_raddr   in   AW    read port 2 address
//  o_rs2_rdata   out  XLEN  read port 2 data (combinational)
//  o_rs2_busy    out  1     read port 2 register has outstanding producer
//  i_alloc_en    in   1     mark i_alloc_addr busy at next edge
//  i_alloc_addr  in   AW    register being allocated as destination
//  i_rd_wen      in   1     write enable
//  i_rd_waddr    in   AW    write address
//  i_rd_wdata    in   XLEN  write data
// BEHAVIOUR
//  - FSM states CLEAR, RUN. Edge with i_rst=1: state<=CLEAR, cnt<=0, o_ready<=0, busy[all]<=0.
//  - CLEAR (i_rst=0): each edge mem[cnt]<=0, cnt<=cnt+1; edge with cnt==NREG-1 -> RUN, o_ready<=1.
//    o_ready rises exactly NREG edges after first edge with i_rst=0. Reset mid-CLEAR restarts cnt at 0.
//  - In CLEAR: i_rd_wen, i_alloc_en ignored; o_rsN_rdata=0, o_rsN_busy=0.
//  - RUN: i_rd_wen && waddr!=0 && waddr<NREG -> mem[waddr]<=wdata, busy[waddr]<=0 at next edge.
//  - i_alloc_en && addr!=0 && addr<NREG -> busy[addr]<=1 at next edge.
//  - Same-edge write and allocate to same addr: data written, busy stays 1 (new producer wins).
//  - Write to non-busy register legal; busy stays 0. Allocate of already-busy register: stays 1.
//  - Reads: addr==0 or addr>=NREG -> data 0, busy 0; else data=mem[addr], busy=busy[addr].
//  - Writes/allocates to addr 0 or addr>=NREG ignored; busy[0] constant 0.
//  - No read latency; write/allocate visible after one edge (unless bypass, below).
//  - o_ready reset value 0; o_rsN_* outputs combinational, 0 while in reset/CLEAR.
// CONFIGURATION
//  RF_BYPASS_EN defined: in RUN, if i_rd_wen && waddr==raddr && raddr!=0 && raddr<NREG, read port
//   returns i_rd_wdata and busy=0 in the same cycle (unless i_alloc_en to same addr same cycle:
//   busy=busy[addr]). Used by pipelined core.
//  RF_BYPASS_EN undefined: reads show only registered state; new data/busy clear visible next cycle.
//   Required for single-cycle cores.
// TESTING
//  1. Reset 1 cycle, NREG=32 -> o_ready=0 for 32 edges, 1 on 32nd; all 32 regs read 0, busy 0.
//  2. Reset asserted at cnt=10 -> cnt restarts at 0; o_ready rises 32 edges after release.
//  3. Alloc x5; next cycle rs1=5 -> busy=1; write x5=0xDEADBEEF -> next cycle data 0xDEADBEEF, busy 0.
//  4. Same edge alloc x7 + write x7=0x1234 -> data 0x1234, busy=1 afterwards.
//  5. Write x0=0xFFFFFFFF, alloc x0 -> rs1=0 reads 0, busy 0.
//  6. Write x9=0xCAFEF00D with rs2=9 same cycle -> RF_BYPASS_EN: data 0xCAFEF00D, busy 0 that cycle;
//     without: old value that cycle, new value next cycle. Run both builds.

Source files
------------

// File: rtl/rf_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf_scoreboard_if
//  Description : Read, allocate and writeback bundle between the pipeline
//                (master: decode + writeback) and rf_scoreboard (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface rf_scoreboard_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            o_ready;
  logic [AW-1:0]   i_rs1_raddr;
  logic [XLEN-1:0] o_rs1_rdata;
  logic            o_rs1_busy;
  logic [AW-1:0]   i_rs2_raddr;
  logic [XLEN-1:0] o_rs2_rdata;
  logic            o_rs2_busy;
  logic            i_alloc_en;
  logic [AW-1:0]   i_alloc_addr;
  logic            i_rd_wen;
  logic [AW-1:0]   i_rd_waddr;
  logic [XLEN-1:0] i_rd_wdata;

  // Pipeline side: drives addresses, allocations and writebacks
  modport master (
    input  o_ready, o_rs1_rdata, o_rs1_busy, o_rs2_rdata, o_rs2_busy,
    output i_rs1_raddr, i_rs2_raddr, i_alloc_en, i_alloc_addr,
           i_rd_wen, i_rd_waddr, i_rd_wdata
  );

  // Register file side
  modport slave (
    output o_ready, o_rs1_rdata, o_rs1_busy, o_rs2_rdata, o_rs2_busy,
    input  i_rs1_raddr, i_rs2_raddr, i_alloc_en, i_alloc_addr,
           i_rd_wen, i_rd_waddr, i_rd_wdata
  );
endinterface
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : rf_scoreboard
//  Description : NREG x XLEN register file, two combinational read ports,
//                one synchronous write port, per-register busy scoreboard
//                and a post-reset sequencer that zeroes one entry per cycle.
//                Optional macro RF_BYPASS_EN forwards same-cycle writeback
//                data/busy-clear onto the read ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_scoreboard #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic           i_clk,
  input  logic           i_rst,
  rf_scoreboard_if.slave bus
);

  localparam logic [0:0]    S_CLEAR    = 1'b0;
  localparam logic [0:0]    S_RUN      = 1'b1;
  localparam logic [AW-1:0] c_last_idx = AW'(NREG - 1);
  localparam logic [31:0]   c_nreg     = 32'(NREG);

  logic [0:0]      r_state;
  logic [0:0]      w_state_nxt;
  logic [AW-1:0]   r_cnt;
  logic [XLEN-1:0] r_mem [NREG];
  logic [NREG-1:0] r_busy;
  logic            w_run;
  logic            w_wr_ok;
  logic            w_alloc_ok;
  logic [AW-1:0]   w_raddr [2];
  logic [XLEN-1:0] w_rdata [2];
  logic            w_rbusy [2];

  // Entry 0 is the hardwired zero register; indices past NREG do not exist
  function automatic logic f_addr_ok(input logic [AW-1:0] a);
    return (a != '0) && (32'(a) < c_nreg);
  endfunction

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_CLEAR;
    else       r_state <= w_state_nxt;
  end

  // Next state: leave CLEAR on the edge that zeroes the last entry
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: if (r_cnt == c_last_idx) w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // State outputs: file is usable only in RUN
  always_comb begin
    w_run = 1'b0;
    case (r_state)
      S_RUN:   w_run = 1'b1;
      default: w_run = 1'b0;
    endcase
  end

  assign w_wr_ok    = w_run && bus.i_rd_wen   && f_addr_ok(bus.i_rd_waddr);
  assign w_alloc_ok = w_run && bus.i_alloc_en && f_addr_ok(bus.i_alloc_addr);

  // Clear-sequence index; restarts from 0 on every reset
  always_ff @(posedge i_clk) begin
    if (i_rst)                  r_cnt <= '0;
    else if (r_state == S_CLEAR) r_cnt <= r_cnt + 1'b1;
  end

  // Storage: zeroed one entry per edge in CLEAR, writeback port in RUN
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (r_state == S_CLEAR) r_mem[r_cnt] <= '0;
      else if (w_wr_ok)       r_mem[bus.i_rd_waddr] <= bus.i_rd_wdata;
    end
  end

  // Scoreboard: writeback clears, allocate sets; allocate is applied last so
  // a new producer on the same edge keeps the register busy
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= '0;
    end else begin
      if (w_wr_ok)    r_busy[bus.i_rd_waddr]   <= 1'b0;
      if (w_alloc_ok) r_busy[bus.i_alloc_addr] <= 1'b1;
    end
  end

  assign w_raddr[0] = bus.i_rs1_raddr;
  assign w_raddr[1] = bus.i_rs2_raddr;

  // Read ports: zero while in reset/CLEAR and for x0 or nonexistent entries
  generate
    for (genvar p = 0; p < 2; p++) begin : g_rd_port
      logic w_ok;
      assign w_ok = w_run && !i_rst && f_addr_ok(w_raddr[p]);
`ifdef RF_BYPASS_EN
      logic w_byp;
      logic w_alloc_same;
      assign w_byp        = w_wr_ok && (bus.i_rd_waddr == w_raddr[p]);
      assign w_alloc_same = w_alloc_ok && (bus.i_alloc_addr == w_raddr[p]);
      assign w_rdata[p]   = !w_ok ? '0 :
                            w_byp ? bus.i_rd_wdata : r_mem[w_raddr[p]];
      // A same-cycle re-allocation suppresses the forwarded busy clear
      assign w_rbusy[p]   = !w_ok ? 1'b0 :
                            (w_byp && !w_alloc_same) ? 1'b0 : r_busy[w_raddr[p]];
`else
      assign w_rdata[p]   = w_ok ? r_mem[w_raddr[p]] : '0;
      assign w_rbusy[p]   = w_ok && r_busy[w_raddr[p]];
`endif
    end
  endgenerate

  assign bus.o_ready     = w_run;
  assign bus.o_rs1_rdata = w_rdata[0];
  assign bus.o_rs1_busy  = w_rbusy[0];
  assign bus.o_rs2_rdata = w_rdata[1];
  assign bus.o_rs2_busy  = w_rbusy[1];

endmodule
`default_nettype wire
